mdu: RTL and testbench

Multiply/divide unit in the E stage of the five-stage MIPS pipeline. It executes mult/multu/div/divu over a fixed multi-cycle latency, holds the HI/LO architectural registers, and serves mthi/mtlo/mfhi/mflo. It consumes the operation code and start strobe produced by the control unit, plus the forwarded E-stage operands. It exports Busy so the stall logic can hold any multiply/divide-class instruction in D while Start or Busy is high.

---
 rtl/mdu_pkg.sv | 30 +++
 rtl/mdu_if.sv | 18 +
 rtl/mdu_calc.sv | 57 +++++
 rtl/mdu.sv | 100 ++++++++++
 tb/tb_mdu.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared types and helpers for the multiply/divide unit
//
// Purpose: MDUOp encodings, FSM state type and the op-class helper used by
//          both the top level and the combinational datapath.
// Ports:   none (package).
package mdu_pkg;

   typedef enum logic [3:0] {
      MDU_NONE  = 4'd0,
      MDU_MULT  = 4'd1,
      MDU_MULTU = 4'd2,
      MDU_DIV   = 4'd3,
      MDU_DIVU  = 4'd4,
      MDU_MTHI  = 4'd5,
      MDU_MTLO  = 4'd6
   } mdu_op_e;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } mdu_state_e;

   localparam int CNT_W = 4;

   // True for the multi-cycle operations (mult/multu/div/divu).
   function automatic logic is_muldiv(input logic [3:0] op);
      return (op >= 4'd1) && (op <= 4'd4);
   endfunction

endpackage

// File: rtl/mdu_if.sv
// rtl/mdu_if.sv - E-stage bundle between pipeline and multiply/divide unit
//
// Purpose: groups the operation request and the HI/LO/Busy results.
// Signals: MDUOp (4) op code, Start (1) E-stage strobe, A/B (32) operands,
//          Busy (1) operation in flight, HI/LO (32) architectural registers.
// Modports: master = pipeline side, slave = mdu side.
interface mdu_if;
   logic [3:0]  MDUOp;
   logic        Start;
   logic [31:0] A;
   logic [31:0] B;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (output MDUOp, Start, A, B, input Busy, HI, LO);
   modport slave  (input MDUOp, Start, A, B, output Busy, HI, LO);
endinterface

// File: rtl/mdu_calc.sv
// rtl/mdu_calc.sv - combinational multiply/divide datapath
//
// Purpose: produces the 64-bit {HI,LO} result for the latched operation.
// Ports:   op_i (op code), a_i/b_i (32) operands,
//          res_o (64) {HI,LO} result, div0_o (1) divide op with zero divisor.
module mdu_calc
   import mdu_pkg::*;
(
   input  mdu_op_e     op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [63:0] res_o,
   output logic        div0_o
);

   logic        signed_op;
   logic        a_neg;
   logic        b_neg;
   logic        res_neg;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] b_div;
   logic [63:0] prod;
   logic [31:0] quo;
   logic [31:0] rem;

   // Both signed and unsigned forms run on magnitudes; signs are reapplied
   // afterwards. |0x80000000| is still representable as an unsigned 32-bit
   // value, so div 0x80000000 / -1 yields 0x80000000 with remainder 0.
   assign signed_op = (op_i == MDU_MULT) || (op_i == MDU_DIV);
   assign a_neg     = signed_op && a_i[31];
   assign b_neg     = signed_op && b_i[31];
   assign res_neg   = a_neg ^ b_neg;
   assign a_mag     = a_neg ? (32'd0 - a_i) : a_i;
   assign b_mag     = b_neg ? (32'd0 - b_i) : b_i;

   assign div0_o    = ((op_i == MDU_DIV) || (op_i == MDU_DIVU)) && (b_i == 32'd0);
   // Keep the divider away from zero; the result is discarded in that case.
   assign b_div     = (b_mag == 32'd0) ? 32'd1 : b_mag;

   assign prod      = {32'd0, a_mag} * {32'd0, b_mag};
   assign quo       = a_mag / b_div;
   assign rem       = a_mag % b_div;

   always_comb begin
      res_o = 64'd0;
      case (op_i)
         MDU_MULT, MDU_MULTU: res_o = res_neg ? (64'd0 - prod) : prod;
         MDU_DIV, MDU_DIVU: begin
            res_o[31:0]  = res_neg ? (32'd0 - quo) : quo;
            res_o[63:32] = a_neg   ? (32'd0 - rem) : rem;
         end
         default: res_o = 64'd0;
      endcase
   end

endmodule

// File: rtl/mdu.sv
// rtl/mdu.sv - E-stage multiply/divide unit with HI/LO registers
//
// Purpose: runs mult/multu/div/divu over a fixed latency and serves mthi/mtlo.
// Ports:   clk (pipeline clock), reset (async, active low),
//          bus (mdu_if.slave): MDUOp/Start/A/B in, Busy/HI/LO out.
module mdu
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
)(
   input  logic  clk,
   input  logic  reset,
   mdu_if.slave  bus
);

   mdu_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   mdu_op_e          op_q, op_d;
   logic [31:0]      a_q, a_d;
   logic [31:0]      b_q, b_d;
   logic [31:0]      hi_q, hi_d;
   logic [31:0]      lo_q, lo_d;
   logic [63:0]      res;
   logic             div0;

   // Datapath sees only latched operands, so forwarding changes on A/B
   // during RUN cannot disturb the in-flight result.
   mdu_calc u_calc (
      .op_i   (op_q),
      .a_i    (a_q),
      .b_i    (b_q),
      .res_o  (res),
      .div0_o (div0)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= MDU_NONE;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         S_IDLE: begin
            if (bus.Start && is_muldiv(bus.MDUOp)) begin
               state_d = S_RUN;
               op_d    = mdu_op_e'(bus.MDUOp);
               a_d     = bus.A;
               b_d     = bus.B;
               cnt_d   = ((bus.MDUOp == MDU_MULT) || (bus.MDUOp == MDU_MULTU))
                         ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            end else if (bus.MDUOp == MDU_MTHI) begin
               hi_d = bus.A;
            end else if (bus.MDUOp == MDU_MTLO) begin
               lo_d = bus.A;
            end
         end
         S_RUN: begin
            // Start, mthi and mtlo are deliberately ignored while running.
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = S_IDLE;
               cnt_d   = '0;
               if (!div0) begin
                  hi_d = res[63:32];
                  lo_d = res[31:0];
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.Busy = (state_q == S_RUN);
   assign bus.HI   = hi_q;
   assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - scoreboard testbench for mdu
module tb_mdu;

   localparam int MC = 5;
   localparam int DC = 10;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic [31:0] old_hi;
      logic [31:0] old_lo;
      int          cycles;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   exp_t sb[$];
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   mdu_if bus ();

   mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endfunction

   // Reference: plain 64-bit arithmetic on sign/zero-extended operands.
   function automatic void model(input int op, input logic [31:0] a, input logic [31:0] b,
                                 inout logic [31:0] hi, inout logic [31:0] lo);
      longint sa, sbv, p, q, r;
      if (op == 1 || op == 3) begin
         sa  = longint'($signed(a));
         sbv = longint'($signed(b));
      end else begin
         sa  = longint'({32'd0, a});
         sbv = longint'({32'd0, b});
      end
      if (op == 1 || op == 2) begin
         p  = sa * sbv;
         hi = p[63:32];
         lo = p[31:0];
      end else if (b != 32'd0) begin
         q  = sa / sbv;
         r  = sa % sbv;
         hi = r[31:0];
         lo = q[31:0];
      end
   endfunction

   task automatic wait_idle();
      int n = 0;
      while (bus.Busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("idle_timeout", 64'd1, 64'd0);
   endtask

   task automatic issue(input int op, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      wait_idle();
      bus.Start = 1'b1;
      bus.MDUOp = 4'(op);
      bus.A     = a;
      bus.B     = b;
      e.old_hi  = m_hi;
      e.old_lo  = m_lo;
      model(op, a, b, m_hi, m_lo);
      e.hi      = m_hi;
      e.lo      = m_lo;
      e.cycles  = (op <= 2) ? MC : DC;
      sb.push_back(e);
      @(negedge clk);
      bus.Start = 1'b0;
      bus.MDUOp = 4'd0;
      bus.A     = $urandom;
      bus.B     = $urandom;
      chk("busy_rise", 64'(bus.Busy), 64'd1);
   endtask

   // Monitor: HI/LO must hold during Busy; on Busy falling, compare result and length.
   int  busy_cnt = 0;
   logic prev_busy = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         busy_cnt  = 0;
         prev_busy = 1'b0;
      end else begin
         if (bus.Busy) begin
            busy_cnt++;
            if (sb.size() == 0) chk("busy_no_op", 64'd1, 64'd0);
            else chk("hold_hilo", {bus.HI, bus.LO}, {sb[0].old_hi, sb[0].old_lo});
         end else if (prev_busy) begin
            if (sb.size() == 0) chk("fall_no_op", 64'd1, 64'd0);
            else begin
               e = sb.pop_front();
               chk("hi", 64'(bus.HI), 64'(e.hi));
               chk("lo", 64'(bus.LO), 64'(e.lo));
               chk("busy_len", 64'(busy_cnt), 64'(e.cycles));
            end
            busy_cnt = 0;
         end
         prev_busy = bus.Busy;
      end
   end

   initial begin
      logic [31:0] ra, rb;
      int          rop, n;
      bus.Start = 1'b0;
      bus.MDUOp = 4'd0;
      bus.A     = 32'd0;
      bus.B     = 32'd0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(bus.Busy), 64'd0);
      chk("rst_hi", 64'(bus.HI), 64'd0);
      chk("rst_lo", 64'(bus.LO), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      issue(1, 32'hFFFFFFFE, 32'd3);
      issue(2, 32'hFFFFFFFF, 32'hFFFFFFFF);
      issue(3, 32'hFFFFFFF9, 32'd2);
      issue(4, 32'd7, 32'd0);

      // mthi in IDLE
      wait_idle();
      bus.MDUOp = 4'd5;
      bus.A     = 32'h12345678;
      @(negedge clk);
      bus.MDUOp = 4'd0;
      chk("mthi_hi", 64'(bus.HI), 64'h12345678);
      chk("mthi_lo", 64'(bus.LO), 64'(m_lo));
      m_hi = 32'h12345678;
      // mtlo in IDLE
      bus.MDUOp = 4'd6;
      bus.A     = 32'hCAFEF00D;
      @(negedge clk);
      bus.MDUOp = 4'd0;
      chk("mtlo_lo", 64'(bus.LO), 64'hCAFEF00D);
      chk("mtlo_hi", 64'(bus.HI), 64'(m_hi));
      m_lo = 32'hCAFEF00D;

      // mtlo and Start while running must be ignored
      issue(1, 32'd100, 32'd200);
      bus.MDUOp = 4'd6;
      bus.A     = 32'hDEADBEEF;
      @(negedge clk);
      bus.MDUOp = 4'd3;
      bus.Start = 1'b1;
      bus.A     = 32'd55;
      bus.B     = 32'd5;
      @(negedge clk);
      bus.Start = 1'b0;
      bus.MDUOp = 4'd0;

      issue(3, 32'h80000000, 32'hFFFFFFFF);
      issue(3, 32'd7, 32'hFFFFFFFE);

      for (int i = 0; i < 40; i++) begin
         rop = $urandom_range(1, 4);
         ra  = $urandom;
         rb  = $urandom;
         n   = $urandom_range(0, 9);
         if (n == 0) rb = 32'd0;
         else if (n < 4) rb = $urandom_range(0, 1) ? 32'($urandom_range(1, 20)) : 32'd0 - 32'($urandom_range(1, 20));
         else if (n == 4) begin
            ra = 32'h80000000;
            rb = 32'hFFFFFFFF;
         end
         issue(rop, ra, rb);
      end

      // Reset mid-division: everything cleared at once, no late write-back.
      issue(3, 32'd1000, 32'd7);
      repeat (2) @(negedge clk);
      #2;
      rst_n = 1'b0;
      sb.delete();
      m_hi = 32'd0;
      m_lo = 32'd0;
      #1;
      chk("arst_busy", 64'(bus.Busy), 64'd0);
      chk("arst_hi", 64'(bus.HI), 64'd0);
      chk("arst_lo", 64'(bus.LO), 64'd0);
      repeat (2) @(negedge clk);
      #2;
      rst_n = 1'b1;
      repeat (15) @(negedge clk);
      chk("post_rst_busy", 64'(bus.Busy), 64'd0);
      chk("post_rst_hilo", {bus.HI, bus.LO}, 64'd0);

      issue(2, 32'h0001_0000, 32'h0001_0000);
      issue(4, 32'hFFFFFFFF, 32'd16);

      n = 0;
      while ((sb.size() != 0 || bus.Busy) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("drain_timeout", 64'd1, 64'd0);
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
